regfile_write_arbiter: RTL and testbench

- Shares the single write port of a bank of 32-bit registers (D/wr/clr/Q register cells) between up to four writeback requesters (ALU, load unit, multiplier, CSR path).
- Round-robin arbitration with a valid/ready handshake per requester.
- Drives the one-hot write enables and the shared data bus into the bank, and sequences a bank-wide clear (flush) on command.

---
 rtl/regfile_write_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_write_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter for a 16 x 32-bit register bank with a single-cycle bank flush.
// Optional macro REGFILE_R0_ZERO_EN makes register 0 read-as-zero: writes to it are accepted but never strobed.
module regfile_write_arbiter #(
   parameter int N_REQ     = 4,
   parameter int REG_COUNT = 16,
   parameter int ADDR_W    = 4,
   parameter int DATA_W    = 32
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      flush_req,
   output logic                      flush_busy,
   output logic [1:0]                grant_id,
   output logic [REG_COUNT-1:0]      reg_wr,
   output logic [DATA_W-1:0]         reg_D,
   output logic                      reg_clr
);

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [1:0]            rr_ptr;
   logic [1:0]            cand;
   logic [1:0]            gnt_idx;
   logic                  gnt_any;
   logic                  xfer;
   logic [ADDR_W-1:0]     sel_addr;
   logic [DATA_W-1:0]     sel_data;
   logic [REG_COUNT-1:0]  wr_dec;

   // Both flush outputs come straight off the state flop so the bank clear is glitch-free.
   assign reg_clr    = (state == FLUSH);
   assign flush_busy = (state == FLUSH);
   assign xfer       = |(req_valid & req_ready);

   // NOTE: every signal driven here gets a default first, otherwise a path that skips the assignment infers a latch.
   always_comb begin
      req_ready = '0;
      gnt_any   = 1'b0;
      gnt_idx   = rr_ptr;
      cand      = rr_ptr;
      if (!clr && state == IDLE && !flush_req) begin
         for (int k = 0; k < N_REQ; k++) begin
            cand = rr_ptr + 2'(k);
            if (!gnt_any && req_valid[cand]) begin
               gnt_any = 1'b1;
               gnt_idx = cand;
            end
         end
         if (gnt_any) req_ready[gnt_idx] = 1'b1;
      end
   end

   // Out-of-range addresses fall through the decoder with no bit set, so they are acked but never written.
   always_comb begin
      sel_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
      sel_data = req_data[gnt_idx*DATA_W +: DATA_W];
      wr_dec   = '0;
      for (int r = 0; r < REG_COUNT; r++) begin
         wr_dec[r] = (sel_addr == ADDR_W'(r));
      end
`ifdef REGFILE_R0_ZERO_EN
      wr_dec[0] = 1'b0;
`else
      wr_dec[0] = (sel_addr == '0);
`endif
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (flush_req) state_nxt = FLUSH;
         FLUSH:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state    <= IDLE;
         rr_ptr   <= 2'd0;
         grant_id <= 2'd0;
         reg_wr   <= '0;
         reg_D    <= '0;
      end else begin
         state  <= state_nxt;
         reg_wr <= '0;
         if (xfer) begin
            rr_ptr   <= gnt_idx + 2'd1;
            grant_id <= gnt_idx;
            reg_wr   <= wr_dec;
            if (|wr_dec) reg_D <= sel_data;
         end
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: reference model plus write scoreboard,
// a second instance with REG_COUNT=12 covers out-of-range addresses.
module tb_regfile_write_arbiter;

   localparam int N_REQ     = 4;
   localparam int REG_COUNT = 16;
   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 32;

   logic                      clk = 1'b0;
   logic                      clr;
   logic [N_REQ-1:0]          req_valid;
   logic [N_REQ*ADDR_W-1:0]   req_addr;
   logic [N_REQ*DATA_W-1:0]   req_data;
   logic                      flush_req;
   logic [N_REQ-1:0]          req_ready;
   logic                      flush_busy;
   logic [1:0]                grant_id;
   logic [REG_COUNT-1:0]      reg_wr;
   logic [DATA_W-1:0]         reg_D;
   logic                      reg_clr;

   logic [N_REQ-1:0]          ready12;
   logic                      busy12;
   logic [1:0]                gid12;
   logic [11:0]               wr12;
   logic [DATA_W-1:0]         d12;
   logic                      clr12;

   regfile_write_arbiter dut (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .flush_req(flush_req), .flush_busy(flush_busy), .grant_id(grant_id),
      .reg_wr(reg_wr), .reg_D(reg_D), .reg_clr(reg_clr)
   );

   regfile_write_arbiter #(.REG_COUNT(12)) dut12 (
      .clk(clk), .clr(clr), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(ready12), .flush_req(flush_req), .flush_busy(busy12), .grant_id(gid12),
      .reg_wr(wr12), .reg_D(d12), .reg_clr(clr12)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [REG_COUNT-1:0] wr;
      logic [DATA_W-1:0]    d;
   } wr_exp_t;

   wr_exp_t              sb[$];
   int                   checks   = 0;
   int                   failures = 0;
   logic                 m_state;
   logic [1:0]           m_ptr;
   logic [1:0]           m_gid;
   logic [DATA_W-1:0]    m_D;

   function automatic logic [REG_COUNT-1:0] exp_dec(input logic [ADDR_W-1:0] a);
      logic [REG_COUNT-1:0] w;
      w    = '0;
      w[a] = 1'b1;
`ifdef REGFILE_R0_ZERO_EN
      if (a == '0) w = '0;
`endif
      return w;
   endfunction

   task automatic reset_model();
      m_state = 1'b0;
      m_ptr   = 2'd0;
      m_gid   = 2'd0;
      m_D     = '0;
      sb.delete();
   endtask

   // One clock: check combinational outputs at the falling edge, registered ones 1ns after the rising edge.
   task automatic step();
      logic [N_REQ-1:0] exp_rdy;
      int               g;
      wr_exp_t          e;
      @(negedge clk);
      exp_rdy = '0;
      g       = -1;
      if (!m_state && !flush_req) begin
         for (int k = 0; k < N_REQ; k++) begin
            int idx;
            idx = (int'(m_ptr) + k) % N_REQ;
            if (g < 0 && req_valid[idx]) g = idx;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      checks++;
      if (req_ready !== exp_rdy) begin
         failures++;
         $display("FAIL sb_ready: got %b expected %b", req_ready, exp_rdy);
      end
      checks++;
      if (flush_busy !== m_state || reg_clr !== m_state) begin
         failures++;
         $display("FAIL sb_flush: busy=%b clr=%b expected %b", flush_busy, reg_clr, m_state);
      end
      if (g >= 0) begin
         e.wr = exp_dec(req_addr[g*ADDR_W +: ADDR_W]);
         e.d  = req_data[g*DATA_W +: DATA_W];
         sb.push_back(e);
         m_ptr = 2'(g + 1);
         m_gid = 2'(g);
      end
      m_state = !m_state && flush_req;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
      end else begin
         e.wr = '0;
         e.d  = m_D;
      end
      if (e.wr != '0) m_D = e.d;
      checks++;
      if (reg_wr !== e.wr) begin
         failures++;
         $display("FAIL sb_reg_wr: got %h expected %h", reg_wr, e.wr);
      end
      checks++;
      if (reg_D !== m_D) begin
         failures++;
         $display("FAIL sb_reg_D: got %h expected %h", reg_D, m_D);
      end
      checks++;
      if (grant_id !== m_gid) begin
         failures++;
         $display("FAIL sb_grant_id: got %0d expected %0d", grant_id, m_gid);
      end
   endtask

   task automatic test_reset();
      clr       = 1'b1;
      flush_req = 1'b0;
      req_valid = 4'b1111;
      req_addr  = {4'h3, 4'h2, 4'h1, 4'h0};
      req_data  = '0;
      #2;
      checks++;
      if (req_ready !== 4'b0000 || reg_wr !== '0 || reg_D !== '0 || grant_id !== 2'd0 ||
          flush_busy !== 1'b0 || reg_clr !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: ready=%b wr=%h D=%h gid=%0d busy=%b clr=%b expected all zero",
                  req_ready, reg_wr, reg_D, grant_id, flush_busy, reg_clr);
      end
      @(posedge clk);
      #2;
      req_valid = 4'b0000;
      clr       = 1'b0;
      reset_model();
      @(posedge clk);
      #1;
   endtask

   task automatic test_round_robin();
      logic [1:0] order [6];
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      req_addr = {4'h7, 4'h6, 4'h5, 4'h4};
      for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = 32'hA000_0000 + 32'(i);
      req_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         #3;
         checks++;
         if (req_ready !== (4'b0001 << order[c])) begin
            failures++;
            $display("FAIL rr_order[%0d]: got %b expected %b", c, req_ready, 4'b0001 << order[c]);
         end
         step();
      end
      req_valid = 4'b0000;
      step();
   endtask

   task automatic test_flush_collision();
      flush_req = 1'b1;
      req_valid = 4'b0011;
      step();
      flush_req = 1'b0;
      #3;
      checks++;
      if (reg_clr !== 1'b1 || flush_busy !== 1'b1 || req_ready !== 4'b0000) begin
         failures++;
         $display("FAIL flush_cycle: clr=%b busy=%b ready=%b expected 1 1 0000", reg_clr, flush_busy, req_ready);
      end
      step();
      #3;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL flush_return_grant: got %b expected 0001", req_ready);
      end
      step();
      req_valid = 4'b0000;
      step();
   endtask

   task automatic test_single_write();
      req_addr  = {4'h0, 4'h3, 4'h0, 4'h0};
      req_data  = '0;
      req_data[2*DATA_W +: DATA_W] = 32'h0000_0003;
      req_valid = 4'b0100;
      #3;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL single_ready: got %b expected 0100", req_ready);
      end
      step();
      req_valid = 4'b0000;
      checks++;
      if (reg_wr !== 16'h0008 || reg_D !== 32'h0000_0003 || grant_id !== 2'd2) begin
         failures++;
         $display("FAIL single_write: wr=%h D=%h gid=%0d expected 0008 00000003 2", reg_wr, reg_D, grant_id);
      end
      step();
      checks++;
      if (reg_wr !== 16'h0000) begin
         failures++;
         $display("FAIL single_pulse_end: got %h expected 0000", reg_wr);
      end
   endtask

   task automatic test_out_of_range();
      req_addr  = {4'h9, 4'h8, 4'hE, 4'h5};
      req_data  = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
      req_valid = 4'b0010;
      #3;
      checks++;
      if (ready12 !== 4'b0010) begin
         failures++;
         $display("FAIL oor_ready: got %b expected 0010", ready12);
      end
      step();
      checks++;
      if (wr12 !== 12'h000) begin
         failures++;
         $display("FAIL oor_no_write: got %h expected 000", wr12);
      end
      req_valid = 4'b1111;
      #3;
      checks++;
      if (ready12 !== 4'b0100) begin
         failures++;
         $display("FAIL oor_ptr_advance: got %b expected 0100", ready12);
      end
      step();
      req_valid = 4'b0000;
      step();
   endtask

   task automatic test_r0();
      req_addr  = {4'h0, 4'h1, 4'h1, 4'h1};
      req_data[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
      req_valid = 4'b1000;
      step();
      req_valid = 4'b0000;
      checks++;
`ifdef REGFILE_R0_ZERO_EN
      if (reg_wr !== 16'h0000) begin
         failures++;
         $display("FAIL r0_zero: got %h expected 0000", reg_wr);
      end
`else
      if (reg_wr !== 16'h0001 || reg_D !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL r0_write: wr=%h D=%h expected 0001 deadbeef", reg_wr, reg_D);
      end
`endif
      step();
   endtask

   task automatic test_flush_repeat();
      flush_req = 1'b1;
      req_valid = 4'b1111;
      step();
      step();
      step();
      flush_req = 1'b0;
      step();
      step();
      req_valid = 4'b0000;
      step();
   endtask

   task automatic test_reset_mid();
      for (int pass = 0; pass < 2; pass++) begin
         flush_req = (pass == 1);
         req_valid = (pass == 0) ? 4'b1111 : 4'b0000;
         step();
         #2;
         clr = 1'b1;
         #1;
         checks++;
         if (req_ready !== 4'b0000 || reg_wr !== '0 || reg_D !== '0 || grant_id !== 2'd0 ||
             flush_busy !== 1'b0 || reg_clr !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid[%0d]: ready=%b wr=%h D=%h gid=%0d busy=%b clr=%b expected all zero",
                     pass, req_ready, reg_wr, reg_D, grant_id, flush_busy, reg_clr);
         end
         flush_req = 1'b0;
         req_valid = 4'b0000;
         clr       = 1'b0;
         reset_model();
         @(posedge clk);
         #1;
      end
      req_valid = 4'b1111;
      #3;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
      end
      step();
      req_valid = 4'b0000;
      step();
   endtask

   initial begin
      reset_model();
      test_reset();
      test_round_robin();
      test_flush_collision();
      test_single_write();
      test_out_of_range();
      test_r0();
      test_flush_repeat();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
